// File: rtl/core_config_sequencer.sv
// Buffers read/write requests and replays them one at a time onto a core's
// configuration bus, returning captured read data on a valid/ready response port.
module core_config_sequencer #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] config_addr,
  output logic [DATA_WIDTH-1:0] config_data,
  output logic                  config_write,
  output logic                  config_read,
  input  logic [DATA_WIDTH-1:0] read_config_data
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned LAT_W = $clog2(READ_LATENCY + 1);

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;

  req_t             fifo_mem [FIFO_DEPTH];
  req_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             push;
  logic             pop;
  logic             idle_nxt;
  state_t           state;
  logic [LAT_W-1:0] lat_cnt;

  assign head = fifo_mem[rd_ptr];

  // FIFO handshake and the next occupancy / idleness used by req_ready and busy
  always_comb begin
    push      = req_valid & req_ready;
    pop       = (state == IDLE) & (count != '0);
    count_nxt = count;
    if (push & ~pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (pop & ~push) begin
      count_nxt = count - CNT_W'(1);
    end
    idle_nxt = 1'b0;
    case (state)
      IDLE:    idle_nxt = ~pop;
      WR:      idle_nxt = 1'b1;
      RD:      idle_nxt = 1'b0;
      RESP:    idle_nxt = resp_ready;
      default: idle_nxt = 1'b1;
    endcase
  end

  // Storage carries no reset; occupancy is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{write: req_write, addr: req_addr, data: req_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      req_ready    <= 1'b1;
      busy         <= 1'b0;
      state        <= IDLE;
      lat_cnt      <= '0;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      config_addr  <= '0;
      config_data  <= '0;
      config_write <= 1'b0;
      config_read  <= 1'b0;
    end else begin
      count     <= count_nxt;
      req_ready <= (count_nxt != CNT_W'(FIFO_DEPTH));
      busy      <= (count_nxt != '0) | ~idle_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      case (state)
        IDLE: begin
          if (pop) begin
            config_addr <= head.addr;
            config_data <= head.data;
            if (head.write) begin
              config_write <= 1'b1;
              state        <= WR;
            end else begin
              config_read <= 1'b1;
              lat_cnt     <= '0;
              state       <= RD;
            end
          end
        end
        WR: begin
          config_write <= 1'b0;
          state        <= IDLE;
        end
        // Hold the read strobe for READ_LATENCY cycles, then sample the core
        RD: begin
          if (lat_cnt == LAT_W'(READ_LATENCY - 1)) begin
            config_read <= 1'b0;
            resp_data   <= read_config_data;
            resp_valid  <= 1'b1;
            state       <= RESP;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_config_sequencer.sv
// Scoreboard bench for core_config_sequencer with a behavioural core register file.
module tb_core_config_sequencer;

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 3;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_data;
  logic          busy;
  logic [AW-1:0] config_addr;
  logic [DW-1:0] config_data;
  logic          config_write;
  logic          config_read;
  logic [DW-1:0] read_config_data;

  core_config_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4), .READ_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .busy(busy),
    .config_addr(config_addr), .config_data(config_data),
    .config_write(config_write), .config_read(config_read),
    .read_config_data(read_config_data)
  );

  int total = 0;
  int bad   = 0;
  int rr_mode = 0;  // 0: always ready, 1: never ready, 2: random

  logic [DW-1:0]    model_mem [256];
  logic [DW-1:0]    core_mem  [256];
  logic [DW-1:0]    exp_rd [$];
  logic [AW+DW-1:0] exp_wr [$];
  int rd_cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Core model: garbage until the final read cycle, then the register contents
  always @(posedge clk) begin
    if (config_write) core_mem[config_addr] <= config_data;
    rd_cyc <= config_read ? rd_cyc + 1 : 0;
  end
  assign read_config_data = (rd_cyc == LAT - 1) ? core_mem[config_addr]
                                                : (32'hBAD0_0000 | 32'(rd_cyc));

  task automatic send_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_data = d;
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check_val("req_accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    if (w) begin
      model_mem[a] = d;
      exp_wr.push_back({a, d});
    end else begin
      exp_rd.push_back(model_mem[a]);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // which: 0 resp_valid, 1 config_read, 2 config_write
  task automatic wait_for(input int which, input string tag);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      hit = (which == 0) ? resp_valid : (which == 1) ? config_read : config_write;
    end
    if (!hit) check_val(tag, 0, 1);
  endtask

  // Response consumer and read scoreboard
  initial begin
    resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rr_mode)
        0:       resp_ready = 1'b1;
        1:       resp_ready = 1'b0;
        default: resp_ready = 1'($urandom_range(0, 1));
      endcase
      if (!reset && resp_valid && resp_ready) begin
        if (exp_rd.size() == 0) check_val("rd_unexpected", 1, 0);
        else check_val("rd_data", resp_data, exp_rd.pop_front());
      end
    end
  end

  // Bus monitor: write order/payload, strobe exclusivity, pulse widths
  initial begin
    int  rd_len;
    logic prev_wr;
    rd_len  = 0;
    prev_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        rd_len  = 0;
        prev_wr = 1'b0;
      end else begin
        if (config_write) begin
          check_val("strobe_overlap", config_read, 0);
          check_val("wr_pulse_width", prev_wr, 0);
          if (exp_wr.size() == 0) check_val("wr_unexpected", 1, 0);
          else check_val("wr_addr_data", {config_addr, config_data}, exp_wr.pop_front());
        end
        if (config_read) begin
          rd_len++;
        end else if (rd_len != 0) begin
          check_val("rd_pulse_width", rd_len, LAT);
          rd_len = 0;
        end
        prev_wr = config_write;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_zero_outs"},
              {config_read, config_write, resp_valid, busy, resp_data, config_addr, config_data},
              '0);
    check_val({tag, "_req_ready"}, req_ready, 1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_rd.size() != 0 || exp_wr.size() != 0 || busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_drain_rd"}, exp_rd.size(), 0);
    check_val({tag, "_drain_wr"}, exp_wr.size(), 0);
    check_val({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = '0;
      core_mem[i]  = '0;
    end
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("init");
    #2 reset = 1'b0;

    // Write then read back, measuring read latency
    rr_mode = 0;
    send_req(1'b1, 8'h01, 32'hDEADBEEF);
    send_req(1'b0, 8'h01, '0);
    wait_for(1, "t1_read_start_timeout");
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("t1_resp_latency", n, LAT);
    drain("t1");

    // Read data changes during the strobe; only the final cycle's value counts
    send_req(1'b1, 8'h03, 32'h12345678);
    send_req(1'b0, 8'h03, '0);
    drain("t4");

    // Stalled response holds steady and blocks further bus traffic
    send_req(1'b1, 8'h00, 32'hA5A50000);
    drain("t3_pre");
    rr_mode = 1;
    send_req(1'b0, 8'h00, '0);
    send_req(1'b1, 8'h02, 32'h22222222);
    wait_for(0, "t3_resp_timeout");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("t3_hold_valid", resp_valid, 1);
      check_val("t3_hold_data", resp_data, 32'hA5A50000);
      check_val("t3_no_strobe", {config_write, config_read}, 0);
    end
    rr_mode = 0;
    @(negedge clk);
    @(negedge clk);
    check_val("t3_valid_clear", resp_valid, 0);
    wait_for(2, "t3_next_issue_timeout");
    check_val("t3_next_addr", config_addr, 8'h02);
    drain("t3");

    // FIFO fills behind a stalled response; fifth request waits for drain
    rr_mode = 1;
    send_req(1'b0, 8'h01, '0);
    wait_for(0, "t2_resp_timeout");
    for (int i = 0; i < 4; i++) send_req(1'b1, 8'(8'h10 + i), 32'hF00D_0000 + 32'(i));
    check_val("t2_full_ready", req_ready, 0);
    fork
      send_req(1'b1, 8'h14, 32'hF00D_0004);
    join_none
    repeat (4) @(negedge clk);
    check_val("t2_still_full", req_ready, 0);
    check_val("t2_fifth_pending", exp_wr.size(), 4);
    rr_mode = 0;
    wait fork;
    for (int i = 0; i < 5; i++) send_req(1'b0, 8'(8'h10 + i), '0);
    drain("t2");

    // Asynchronous reset in the middle of a read
    send_req(1'b0, 8'hF0, '0);
    wait_for(1, "t5_rd_timeout");
    #2 reset = 1'b1;
    #1 check_reset_outputs("t5_rd");
    exp_rd.delete();
    exp_wr.delete();
    @(negedge clk);
    #2 reset = 1'b0;
    // Asynchronous reset in the middle of a write with a request still queued
    send_req(1'b1, 8'hF1, 32'h1);
    send_req(1'b1, 8'hF2, 32'h2);
    send_req(1'b1, 8'hF3, 32'h3);
    wait_for(2, "t5_wr_timeout");
    #2 reset = 1'b1;
    #1 check_reset_outputs("t5_wr");
    exp_rd.delete();
    exp_wr.delete();
    @(negedge clk);
    #2 reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_val("t5_quiet", {resp_valid, busy, config_write, config_read}, 0);
    end
    send_req(1'b1, 8'h20, 32'hC0FFEE01);
    send_req(1'b0, 8'h20, '0);
    drain("t5");

    // Random traffic against the scoreboard with random response back-pressure
    rr_mode = 2;
    for (int i = 0; i < 200; i++) begin
      send_req(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom);
    end
    rr_mode = 0;
    drain("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
